// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters; ILLEGAL_OP_CHECK_EN adds illegal-opcode error responses
module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 4,
  parameter int NUM_OPS = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
`ifdef ILLEGAL_OP_CHECK_EN
  output logic              rsp0_err,
  output logic              rsp1_err,
`endif
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_c,
  output logic              busy,
  output logic              grant_id
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, id_q, id_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, d0_q, d0_d, d1_q, d1_d;
  logic [SEL_W-1:0] alu_sel_q, alu_sel_d;
  logic any_req, win, illegal, done;
  logic [DATA_W-1:0] win_a, win_b;
  logic [SEL_W-1:0] win_sel;
  always_comb begin
    any_req = req0_valid | req1_valid;
    win = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    win_a = win ? req1_a : req0_a;
    win_b = win ? req1_b : req0_b;
    win_sel = win ? req1_sel : req0_sel;
`ifdef ILLEGAL_OP_CHECK_EN
    illegal = win_sel >= SEL_W'(NUM_OPS);
`else
    illegal = 1'b0;
`endif
    done = (state_q == RESP) & (id_q ? rsp1_ready : rsp0_ready);
    req0_ready = (state_q == IDLE) & any_req & ~win;
    req1_ready = (state_q == IDLE) & any_req & win;
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_sel_d = alu_sel_q;
    d0_d = d0_q;
    d1_d = d1_q;
    if (state_q == IDLE && any_req) begin
      state_d = illegal ? RESP : EXEC;
      id_d = win;
      if (!illegal) begin
        alu_a_d = win_a;
        alu_b_d = win_b;
        alu_sel_d = win_sel;
      end else if (win) d1_d = '0;
      else d0_d = '0;
    end
    if (state_q == EXEC) begin
      state_d = RESP;
      if (id_q) d1_d = alu_c;
      else d0_d = alu_c;
    end
    if (done) begin
      state_d = IDLE;
      last_d = id_q;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_sel_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_sel_q <= alu_sel_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
    end
`ifdef ILLEGAL_OP_CHECK_EN
  logic e0_q, e0_d, e1_q, e1_d;
  always_comb begin
    e0_d = req0_ready ? illegal : e0_q;
    e1_d = req1_ready ? illegal : e1_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e0_q <= 1'b0;
      e1_q <= 1'b0;
    end else begin
      e0_q <= e0_d;
      e1_q <= e1_d;
    end
  assign rsp0_err = e0_q;
  assign rsp1_err = e1_q;
`endif
  assign rsp0_valid = (state_q == RESP) & ~id_q;
  assign rsp1_valid = (state_q == RESP) & id_q;
  assign rsp0_data = d0_q;
  assign rsp1_data = d1_q;
  assign alu_a = alu_a_q;
  assign alu_b = alu_b_q;
  assign alu_sel = alu_sel_q;
  assign busy = state_q != IDLE;
  assign grant_id = id_q;
endmodule
